// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA 5x5 window generator: pixel width default,
// window size, sequencer states and the flat window element index.
package cfa_pkg;

    localparam int PIX_W_DEFAULT = 12;
    localparam int WIN_N         = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        ACTIVE = 2'd2
    } cfa_state_t;

    // Flat slot of window element eRtC (R = row 1..5, C = column 1..5).
    function automatic int idx(input int r, input int c);
        return (r - 1) * WIN_N + (c - 1);
    endfunction

endpackage

// File: rtl/cfa_line_buf.sv
// Circular delay line: each enabled cycle reads the oldest sample and
// overwrites it with the new one at the same address. The output is therefore
// the sample written exactly DEPTH enabled cycles earlier.
// Contents are never cleared; only the pointer is reset.
module cfa_line_buf #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]    ptr_reg;

    // The tap has to be valid at the accepting edge itself, so the read is asynchronous.
    assign dout = mem[ptr_reg];

    // Write the incoming sample over the slot that was just read out.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr_reg] <= din;
        end
    end

    // Pointer steps once per accepted sample and wraps at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg <= '0;
        end else if (en) begin
            if (ptr_reg == AW'(DEPTH - 1)) begin
                ptr_reg <= '0;
            end else begin
                ptr_reg <= ptr_reg + AW'(1);
            end
        end
    end

endmodule

// File: rtl/cfa_window5x5.sv
// Bayer raster stream to 5x5 neighbourhood. Four cascaded line buffers feed
// the right-hand column of a 5x5 shift array; a window is flagged one cycle
// after any pixel at row>=4, col>=4 is accepted.
// Optional: define CFA_WIN_COORD_EN to add win_row/win_col (centre coordinate).
module cfa_window5x5
    import cfa_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEFAULT,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pix_valid,
    input  logic                         sof,
    input  logic [PIX_W-1:0]             pix_in,
    output logic                         win_valid,
    output logic [WIN_N*WIN_N*PIX_W-1:0] win,
    output logic                         frame_done
`ifdef CFA_WIN_COORD_EN
    ,
    output logic [$clog2(IMG_H)-1:0]     win_row,
    output logic [$clog2(IMG_W)-1:0]     win_col
`endif
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    // Raster position tracking
    logic [ROW_W-1:0] row_reg, row_next, eff_row;
    logic [COL_W-1:0] col_reg, col_next, eff_col;
    logic             wrap;

    cfa_state_t state_reg, state_next;

    logic win_valid_reg, win_valid_next;
    logic frame_done_reg, frame_done_next;

    logic [WIN_N*WIN_N*PIX_W-1:0] win_reg, win_flat_next;

    // tap[0] is the live pixel, tap[k] the same column k rows above.
    logic [PIX_W-1:0] tap [0:WIN_N-1];

    logic [PIX_W-1:0] arr_reg  [0:WIN_N-1][0:WIN_N-1];
    logic [PIX_W-1:0] arr_next [0:WIN_N-1][0:WIN_N-1];

    assign tap[0] = pix_in;

    genvar gi, gj;

    generate
        for (gi = 0; gi < WIN_N - 1; gi++) begin : g_lb
            cfa_line_buf #(
                .DEPTH (IMG_W),
                .WIDTH (PIX_W)
            ) u_line_buf (
                .clk  (clk),
                .rst  (rst),
                .en   (pix_valid),
                .din  (tap[gi]),
                .dout (tap[gi+1])
            );
        end
    endgenerate

    // Coordinate of the pixel being accepted (sof forces 0,0) and counter advance.
    always_comb begin
        eff_row  = sof ? '0 : row_reg;
        eff_col  = sof ? '0 : col_reg;
        row_next = row_reg;
        col_next = col_reg;
        wrap     = 1'b0;
        if (pix_valid) begin
            if (eff_col == COL_W'(IMG_W - 1)) begin
                col_next = '0;
                if (eff_row == ROW_W'(IMG_H - 1)) begin
                    row_next = '0;
                    wrap     = 1'b1;
                end else begin
                    row_next = eff_row + ROW_W'(1);
                end
            end else begin
                col_next = eff_col + COL_W'(1);
                row_next = eff_row;
            end
        end
    end

    // Sequencer: FILL covers rows 0-3, ACTIVE is the only state that can flag windows.
    always_comb begin
        state_next      = state_reg;
        win_valid_next  = 1'b0;
        frame_done_next = pix_valid & wrap;
        case (state_reg)
            IDLE: begin
                if (pix_valid) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (pix_valid && eff_row == ROW_W'(4) && eff_col == '0) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                win_valid_next = pix_valid && (eff_row >= ROW_W'(4)) && (eff_col >= COL_W'(4));
                if (pix_valid && (sof || wrap)) begin
                    state_next = FILL;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift the array one column left on accept; the new column comes from the taps.
    always_comb begin
        for (int r = 0; r < WIN_N; r++) begin
            for (int c = 0; c < WIN_N; c++) begin
                arr_next[r][c] = arr_reg[r][c];
            end
        end
        if (pix_valid) begin
            for (int r = 0; r < WIN_N; r++) begin
                for (int c = 0; c < WIN_N - 1; c++) begin
                    arr_next[r][c] = arr_reg[r][c+1];
                end
                arr_next[r][WIN_N-1] = tap[WIN_N-1-r];
            end
        end
    end

    generate
        for (gi = 0; gi < WIN_N; gi++) begin : g_row
            for (gj = 0; gj < WIN_N; gj++) begin : g_col
                localparam int K = idx(gi + 1, gj + 1);
                assign win_flat_next[K*PIX_W +: PIX_W] = arr_next[gi][gj];
            end
        end
    endgenerate

    // Shift array storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < WIN_N; r++) begin
                for (int c = 0; c < WIN_N; c++) begin
                    arr_reg[r][c] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < WIN_N; r++) begin
                for (int c = 0; c < WIN_N; c++) begin
                    arr_reg[r][c] <= arr_next[r][c];
                end
            end
        end
    end

    // Counters, state and outputs; the window output only loads on a flagged window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_reg        <= '0;
            col_reg        <= '0;
            state_reg      <= IDLE;
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            win_reg        <= '0;
        end else begin
            row_reg        <= row_next;
            col_reg        <= col_next;
            state_reg      <= state_next;
            win_valid_reg  <= win_valid_next;
            frame_done_reg <= frame_done_next;
            if (win_valid_next) begin
                win_reg <= win_flat_next;
            end
        end
    end

    assign win_valid  = win_valid_reg;
    assign win        = win_reg;
    assign frame_done = frame_done_reg;

`ifdef CFA_WIN_COORD_EN
    logic [ROW_W-1:0] win_row_reg;
    logic [COL_W-1:0] win_col_reg;

    // Centre coordinate registered alongside the window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_row_reg <= '0;
            win_col_reg <= '0;
        end else if (win_valid_next) begin
            win_row_reg <= eff_row - ROW_W'(2);
            win_col_reg <= eff_col - COL_W'(2);
        end
    end

    assign win_row = win_row_reg;
    assign win_col = win_col_reg;
`endif

endmodule

// File: tb/tb_cfa_window5x5.sv
// Directed bench for cfa_window5x5 with an 8x8 image, pixel = row*16 + col.
// Build with +define+CFA_WIN_COORD_EN to also check the centre coordinate.
module tb_cfa_window5x5;

    localparam int PW = 12;
    localparam int W  = 8;
    localparam int H  = 8;

    logic          clk;
    logic          rst;
    logic          pix_valid;
    logic          sof;
    logic [PW-1:0] pix_in;
    logic          win_valid;
    logic [25*PW-1:0] win;
    logic          frame_done;
`ifdef CFA_WIN_COORD_EN
    logic [2:0]    win_row;
    logic [2:0]    win_col;
`endif

    cfa_window5x5 #(
        .PIX_W (PW),
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .pix_in     (pix_in),
        .win_valid  (win_valid),
        .win        (win),
        .frame_done (frame_done)
`ifdef CFA_WIN_COORD_EN
        ,
        .win_row    (win_row),
        .win_col    (win_col)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int e11, e15, e33, e51, e55, acc, wr, wc;
    } win_t;

    win_t q[$];
    int   fd_q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   acc_cnt = 0;
    int   stray_cnt = 0;
    int   hold_err  = 0;
    logic pv_edge = 1'b0;
    logic [25*PW-1:0] prev_win = '0;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int el(input logic [25*PW-1:0] w, input int r, input int c);
        return int'(w[((r - 1) * 5 + (c - 1)) * PW +: PW]);
    endfunction

    // Count accepts and remember whether the last edge carried a pixel.
    always @(posedge clk) begin
        pv_edge <= pix_valid;
        if (rst && pix_valid) acc_cnt <= acc_cnt + 1;
    end

    // Capture windows and frame_done pulses; flag strobes without an accept and
    // window changes without a strobe.
    always @(negedge clk) begin : mon
        win_t w;
        if (rst) begin
            if (win_valid) begin
                w.e11 = el(win, 1, 1);
                w.e15 = el(win, 1, 5);
                w.e33 = el(win, 3, 3);
                w.e51 = el(win, 5, 1);
                w.e55 = el(win, 5, 5);
                w.acc = acc_cnt;
`ifdef CFA_WIN_COORD_EN
                w.wr  = int'(win_row);
                w.wc  = int'(win_col);
`else
                w.wr  = 0;
                w.wc  = 0;
`endif
                q.push_back(w);
                $display("window #%0d acc=%0d e11=%03h e33=%03h e55=%03h", q.size(), w.acc, w.e11, w.e33, w.e55);
                if (!pv_edge) stray_cnt++;
            end
            if (frame_done) fd_q.push_back(acc_cnt);
            if (!win_valid && win != prev_win) hold_err++;
        end
        prev_win = win;
    end

    task automatic drive(input logic v, input logic s, input logic [PW-1:0] p);
        @(negedge clk);
        #1;
        pix_valid = v;
        sof       = s;
        pix_in    = p;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'($urandom_range(0, 1)), PW'($urandom));
    endtask

    task automatic send_frame(input bit with_sof, input int gap, input int npix);
        for (int i = 0; i < npix; i++) begin
            drive(1'b1, with_sof && (i == 0), PW'((i / W) * 16 + (i % W)));
            idle(gap);
        end
    endtask

    task automatic check_reset(input string tag);
        @(negedge clk);
        check({tag, "_win_valid"}, int'(win_valid), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_win_zero"}, int'(|win), 0);
    endtask

    // Sixteen windows starting at queue slot qb, acc counts relative to ab.
    task automatic check_frame(input string tag, input int qb, input int ab);
        for (int k = 0; k < 16 && qb + k < q.size(); k++) begin
            int   r;
            int   c;
            win_t w;
            w = q[qb + k];
            r = 4 + k / 4;
            c = 4 + k % 4;
            check({tag, "_e55"}, w.e55, r * 16 + c);
            check({tag, "_e11"}, w.e11, (r - 4) * 16 + (c - 4));
            check({tag, "_e15"}, w.e15, (r - 4) * 16 + c);
            check({tag, "_e51"}, w.e51, r * 16 + (c - 4));
            check({tag, "_e33"}, w.e33, (r - 2) * 16 + (c - 2));
            check({tag, "_latency"}, w.acc, ab + r * W + c + 1);
`ifdef CFA_WIN_COORD_EN
            if (k == 0 || k == 15) begin
                check({tag, "_win_row"}, w.wr, r - 2);
                check({tag, "_win_col"}, w.wc, c - 2);
            end
`endif
        end
    endtask

    initial begin
        int qb;
        int ab;
        int fb;
        rst       = 1'b0;
        pix_valid = 1'b0;
        sof       = 1'b0;
        pix_in    = '0;

        // Reset with random inputs
        repeat (6) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), PW'($urandom));
        check_reset("rst_init");
        @(negedge clk);
        #1 rst = 1'b1;
        idle(2);

        // Continuous frame
        qb = q.size(); ab = acc_cnt; fb = fd_q.size();
        send_frame(1'b1, 0, 64);
        idle(3);
        check("cont_count", q.size() - qb, 16);
        check_frame("cont", qb, ab);
        check("cont_fd_count", fd_q.size() - fb, 1);
        if (fd_q.size() > fb) check("cont_fd_time", fd_q[fb], ab + 64);

        // Gapped frame: one accept in three cycles
        qb = q.size(); ab = acc_cnt; fb = fd_q.size();
        send_frame(1'b1, 2, 64);
        idle(3);
        check("gap_count", q.size() - qb, 16);
        check_frame("gap", qb, ab);
        check("gap_fd_count", fd_q.size() - fb, 1);

        // sof abort at row 5 col 2
        qb = q.size();
        send_frame(1'b1, 0, 42);
        idle(2);
        check("abort_partial_count", q.size() - qb, 4);
        qb = q.size(); ab = acc_cnt; fb = fd_q.size();
        send_frame(1'b1, 0, 64);
        idle(3);
        check("abort_count", q.size() - qb, 16);
        check_frame("abort", qb, ab);
        check("abort_fd_count", fd_q.size() - fb, 1);

        // Back-to-back frames, second one relies on counter wrap
        qb = q.size(); ab = acc_cnt; fb = fd_q.size();
        send_frame(1'b1, 0, 64);
        send_frame(1'b0, 0, 64);
        idle(3);
        check("b2b_count", q.size() - qb, 32);
        check_frame("b2b_f1", qb, ab);
        check_frame("b2b_f2", qb + 16, ab + 64);
        check("b2b_fd_count", fd_q.size() - fb, 2);
        if (fd_q.size() > fb + 1) begin
            check("b2b_fd1_time", fd_q[fb], ab + 64);
            check("b2b_fd2_time", fd_q[fb + 1], ab + 128);
        end

        // sof on the final pixel position suppresses frame_done
        qb = q.size(); ab = acc_cnt; fb = fd_q.size();
        send_frame(1'b1, 0, 63);
        send_frame(1'b1, 0, 64);
        idle(3);
        check("sof_last_count", q.size() - qb, 31);
        check_frame("sof_last", qb + 15, ab + 63);
        check("sof_last_fd_count", fd_q.size() - fb, 1);
        if (fd_q.size() > fb) check("sof_last_fd_time", fd_q[fb], ab + 127);

        // Reset mid-frame, then a frame without sof
        qb = q.size();
        send_frame(1'b1, 0, 40);
        idle(1);
        check("mid_pre_count", q.size() - qb, 4);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), PW'($urandom));
        check_reset("rst_mid");
        @(negedge clk);
        #1 rst = 1'b1;
        pix_valid = 1'b0;
        qb = q.size(); ab = acc_cnt; fb = fd_q.size();
        send_frame(1'b0, 0, 64);
        idle(3);
        check("mid_count", q.size() - qb, 16);
        check_frame("mid", qb, ab);
        check("mid_fd_count", fd_q.size() - fb, 1);

        check("no_stray_strobe", stray_cnt, 0);
        check("win_hold", hold_err, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cfa_window5x5.md
Name: cfa_window5x5

Overview:
- Upstream neighbour of the 5x5 gradient stage.
- Accepts a raster Bayer pixel stream, one 12-bit pixel per valid cycle.
- Uses four line buffers and a 5x5 register array to present a full 5x5 neighbourhood.
- Drives the gradient stage's start strobe, so each valid window is consumed in the same cycle it is flagged.

Parameters:
- PIX_W, 12, pixel width in bits.
- IMG_W, 64, active pixels per line; must be at least 5.
- IMG_H, 64, active lines per frame; must be at least 5.

Ports:
- clk  in  1  Single clock, rising-edge.
- rst  in  1  Asynchronous, active-low reset.
- pix_valid  in  1  Qualifies pix_in and sof; no backpressure.
- sof  in  1  Start of frame; marks the pixel at row 0, col 0.
- pix_in  in  PIX_W  Raster pixel.
- win_valid  out  1  One-cycle strobe; drives the downstream start.
- win  out  25*PIX_W  Window; element eRtC sits at bits [((R-1)*5+(C-1))*PIX_W +: PIX_W].
- frame_done  out  1  One-cycle pulse after the last pixel of a frame.

Behaviour:
- Reset (rst low, asynchronous):
  - win, win_valid, frame_done, row/col counters and the state all go to 0.
  - Line-buffer contents need not be cleared.
- A pixel is accepted on each clk edge with pix_valid=1.
- Gap cycles (pix_valid=0) hold every register; win_valid=0 during gaps.
- Counters: col runs 0..IMG_W-1, then row increments and col returns to 0.
  - After (IMG_H-1, IMG_W-1): row and col wrap to 0 and frame_done pulses the next cycle.
- sof with pix_valid: the pixel is taken as (0,0) regardless of counter state, which aborts any partial frame.
- Line buffers:
  - Four cascaded delay lines of depth IMG_W.
  - On accept, tap k (k=1..4) yields the pixel at (row-k, col).
  - Taps and pix_in shift the 5x5 array one column left.
  - Column 5 receives the new samples: e5 = current row, e1 = row-4.
- Window mapping:
  - e5t5 = current pixel (r,c).
  - e1t1 = (r-4, c-4).
  - e3t3 = centre (r-2, c-2).
- win_valid:
  - Registered; asserted in the cycle after the accepting edge of a pixel with row>=4 and col>=4.
  - win is updated on that same edge.
  - Latency is 1 cycle from pixel accept to window.
  - Each frame yields (IMG_H-4)*(IMG_W-4) windows.
  - No border padding: windows straddling a line wrap are never flagged.
- win holds its last value when win_valid=0.
- State machine, advancing on accept:
  - IDLE (after reset) → FILL on the first accepted pixel, or on sof.
  - FILL (rows 0-3) → ACTIVE when row 4 col 0 is accepted.
  - ACTIVE → FILL on frame wrap or sof.
  - win_valid is only possible in ACTIVE.
- Simultaneous events:
  - sof on the final pixel position: sof wins, no frame_done.
  - frame_done and a new pixel in the same cycle are legal.
- Reset mid-frame: all of the above return to reset values; the next accepted pixel is treated as (0,0).

Optional Feature:
- Macro: CFA_WIN_COORD_EN.
- Defined:
  - Adds output win_row (clog2(IMG_H) bits) and output win_col (clog2(IMG_W) bits).
  - Both carry the centre-pixel coordinate (r-2, c-2).
  - Both are registered alongside win, reset to 0, and hold between windows.
  - Used to select the Bayer phase downstream.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package cfa_pkg holds:
  - PIX_W default.
  - WIN_N=5.
  - The state enumeration (IDLE, FILL, ACTIVE).
  - The window index function idx(R,C)=(R-1)*5+(C-1).
- One sub-module, cfa_line_buf:
  - Parameterised depth and width.
  - Circular RAM with an enable-gated write and read at the same address, giving a delay of exactly IMG_W accepts.
  - Instantiated four times.

Test Plan:
- Bench settings: IMG_W=8, IMG_H=8, pixel value = row*16 + col.
- Reset test: hold rst=0 with random inputs → win=0, win_valid=0, frame_done=0. Assert rst mid-frame → same result, and the next pixel is treated as (0,0).
- Continuous frame:
  - First win_valid one cycle after the 37th pixel (0x44), with e1t1=0x00, e3t3=0x22, e5t5=0x44.
  - Exactly 16 win_valid pulses.
  - Last window has e5t5=0x77.
  - frame_done pulses once.
- Gapped stream: pix_valid high one cycle in three → identical sequence of 16 windows and values as the continuous frame; no strobes during gaps.
- sof abort: sof with pixel 0x00 at row 5 col 2 → state FILL, no win_valid until the new (4,4), then e3t3=0x22.
- Back-to-back frames with no gap → frame_done, then the second frame produces its first window at the 37th pixel of that frame, with no stale-row windows.
- CFA_WIN_COORD_EN defined → first window gives win_row=2, win_col=2; last window gives 5,5.
